// File: rtl/decode_stage_pipelined.sv
// ---------------------------------------------------------------------------
// decode_stage_pipelined
//
// Decode stage with a 2^ADDR_W x DATA_W register file (two combinational read
// ports, one write port), write-to-read bypass, an immediate operand mux and
// a registered ID/EX boundary with valid / stall / flush control.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid                decode slot holds a real instruction
//   stall                   hold ID/EX contents
//   flush                   replace ID/EX contents with a bubble (beats stall)
//   src_addr                port A read address
//   dst_addr                port B read address, also forwarded to ID/EX
//   use_imm, imm            select imm instead of port B for alu_input2
//   write_back, write_addr,
//   write_data              register file write port (from write-back)
//   out_valid               ID/EX slot valid
//   read_data1              registered port A operand
//   alu_input2              registered second ALU operand (port B or imm)
//   store_data              registered raw port B data
//   out_dst_addr            registered dst_addr
// ---------------------------------------------------------------------------
module decode_stage_pipelined #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic              write_back,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] alu_input2,
  output logic [DATA_W-1:0] store_data,
  output logic [ADDR_W-1:0] out_dst_addr
);

  localparam int NUM_REGS = 1 << ADDR_W;

  // Register file. The whole array is cleared by reset, so it is built from
  // flops rather than a RAM macro.
  logic [DATA_W-1:0] regs_reg [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (write_back) begin
      regs_reg[write_addr] <= write_data;
    end
  end

  // Combinational reads with bypass: a write on this edge is visible to the
  // operands captured on the same edge.
  logic [DATA_W-1:0] port_a;
  logic [DATA_W-1:0] port_b;
  logic [DATA_W-1:0] op_b;

  always_comb begin
    port_a = regs_reg[src_addr];
    port_b = regs_reg[dst_addr];
    if (write_back && (write_addr == src_addr)) begin
      port_a = write_data;
    end
    if (write_back && (write_addr == dst_addr)) begin
      port_b = write_data;
    end
    op_b = use_imm ? imm : port_b;
  end

  // ID/EX boundary. Data fields capture even for bubbles; only out_valid
  // qualifies them downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      read_data1   <= '0;
      alu_input2   <= '0;
      store_data   <= '0;
      out_dst_addr <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      read_data1   <= '0;
      alu_input2   <= '0;
      store_data   <= '0;
      out_dst_addr <= '0;
    end else if (!stall) begin
      out_valid    <= in_valid;
      read_data1   <= port_a;
      alu_input2   <= op_b;
      store_data   <= port_b;
      out_dst_addr <= dst_addr;
    end
    // stall without flush: hold everything, held operands are not refreshed
  end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_pipelined
//
// Directed scenarios with literal expectations, followed by randomized
// stimulus (including asynchronous reset pulses) checked every cycle against
// a behavioural model of the decode stage.
// ---------------------------------------------------------------------------
module tb_decode_stage_pipelined;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic          use_imm = 1'b0;
  logic [DW-1:0] imm = '0;
  logic          write_back = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          out_valid;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] alu_input2;
  logic [DW-1:0] store_data;
  logic [AW-1:0] out_dst_addr;

  always #5 clk = ~clk;

  decode_stage_pipelined #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .flush(flush), .src_addr(src_addr), .dst_addr(dst_addr),
    .use_imm(use_imm), .imm(imm), .write_back(write_back),
    .write_addr(write_addr), .write_data(write_data),
    .out_valid(out_valid), .read_data1(read_data1),
    .alu_input2(alu_input2), .store_data(store_data),
    .out_dst_addr(out_dst_addr)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_rf [NR];
  logic          m_valid;
  logic [DW-1:0] m_rd1, m_alu2, m_st;
  logic [AW-1:0] m_dst;
  logic [DW-1:0] m_a, m_b;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
    if (write_back && write_addr == addr) return write_data;
    return m_rf[addr];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
      m_valid = 1'b0; m_rd1 = '0; m_alu2 = '0; m_st = '0; m_dst = '0;
    end else begin
      m_a = model_read(src_addr);
      m_b = model_read(dst_addr);
      if (flush) begin
        m_valid = 1'b0; m_rd1 = '0; m_alu2 = '0; m_st = '0; m_dst = '0;
      end else if (!stall) begin
        m_valid = in_valid;
        m_rd1   = m_a;
        m_alu2  = use_imm ? imm : m_b;
        m_st    = m_b;
        m_dst   = dst_addr;
      end
      if (write_back) m_rf[write_addr] = write_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check_val("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check_val("cyc_read_data1", {16'b0, read_data1}, {16'b0, m_rd1});
      check_val("cyc_alu_input2", {16'b0, alu_input2}, {16'b0, m_alu2});
      check_val("cyc_store_data", {16'b0, store_data}, {16'b0, m_st});
      check_val("cyc_out_dst_addr", {29'b0, out_dst_addr}, {29'b0, m_dst});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; src_addr = 0; dst_addr = 0;
    use_imm = 0; imm = 0; write_back = 0; write_addr = 0; write_data = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_back = 1; write_addr = a; write_data = d;
  endtask

  task automatic rd(input logic [AW-1:0] s, input logic [AW-1:0] d);
    in_valid = 1; src_addr = s; dst_addr = d;
  endtask

  task automatic outs(input string tag, input logic v, input logic [DW-1:0] r1,
                      input logic [DW-1:0] a2, input logic [DW-1:0] st,
                      input logic [AW-1:0] da);
    check_val({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    check_val({tag, "_rd1"}, {16'b0, read_data1}, {16'b0, r1});
    check_val({tag, "_alu2"}, {16'b0, alu_input2}, {16'b0, a2});
    check_val({tag, "_store"}, {16'b0, store_data}, {16'b0, st});
    check_val({tag, "_dst"}, {29'b0, out_dst_addr}, {29'b0, da});
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset mid-operation: preload reg3 and capture it, then pulse reset.
    @(negedge clk); idle(); wr(3, 16'h1234); rd(3, 3);
    @(negedge clk); idle();
    outs("pre_reset", 1, 16'h1234, 16'h1234, 16'h1234, 3);
    #2 rst_n = 1'b0;
    #1 outs("in_reset", 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    rd(3, 0);
    @(negedge clk); idle();
    outs("after_reset", 1, 0, 0, 0, 0);

    // Write then read.
    wr(5, 16'hBEEF);
    @(negedge clk); idle(); rd(5, 0);
    @(negedge clk); idle();
    check_val("wr_rd_rd1", {16'b0, read_data1}, 32'h0000_BEEF);
    check_val("wr_rd_valid", {31'b0, out_valid}, 32'd1);

    // Same-cycle bypass on both ports.
    wr(2, 16'h00A5); rd(2, 2);
    @(negedge clk); idle();
    outs("bypass", 1, 16'h00A5, 16'h00A5, 16'h00A5, 2);

    // Immediate operand.
    wr(1, 16'h0010);
    @(negedge clk); idle(); rd(0, 1); use_imm = 1; imm = 16'hFFF0;
    @(negedge clk); idle();
    check_val("imm_alu2", {16'b0, alu_input2}, 32'h0000_FFF0);
    check_val("imm_store", {16'b0, store_data}, 32'h0000_0010);
    check_val("imm_dst", {29'b0, out_dst_addr}, 32'd1);

    // Stall holds operands while reg4 is overwritten.
    wr(4, 16'h1111);
    @(negedge clk); idle(); rd(4, 0);
    @(negedge clk); idle();
    check_val("stall_cap", {16'b0, read_data1}, 32'h0000_1111);
    for (int k = 0; k < 3; k++) begin
      stall = 1; wr(4, 16'h2222); rd(4, 4);
      @(negedge clk); idle();
      check_val("stall_hold_rd1", {16'b0, read_data1}, 32'h0000_1111);
      check_val("stall_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    rd(4, 0);
    @(negedge clk); idle();
    check_val("stall_release", {16'b0, read_data1}, 32'h0000_2222);

    // Flush beats stall; concurrent write still lands.
    stall = 1; flush = 1; wr(6, 16'h6666); rd(4, 4);
    @(negedge clk); idle();
    outs("flush", 0, 0, 0, 0, 0);
    rd(6, 0);
    @(negedge clk); idle();
    check_val("flush_write_landed", {16'b0, read_data1}, 32'h0000_6666);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid   = 1'($urandom);
      stall      = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      src_addr   = AW'($urandom);
      dst_addr   = AW'($urandom);
      use_imm    = 1'($urandom);
      imm        = DW'($urandom);
      write_back = 1'($urandom);
      write_addr = AW'($urandom);
      write_data = DW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
